gbc_hdma_engine: RTL and testbench
==================================

Name: gbc_hdma_engine

Overview:
GBC VRAM DMA (HDMA) controller. It sits directly upstream of the GBC memory bus as a second Wishbone initiator, alongside the CPU. It owns registers FF51–FF55 and copies 16-byte blocks from cartridge/WRAM space into VRAM 0x8000–0x9FFF. Copies run either in one burst (general-purpose mode) or one block per HBlank. CPU_HALT tells the CPU arbiter to yield the bus.

Parameters:
AddressWidth, 16, Wishbone address width toward the memory bus
DataWidth, 8, Wishbone data width
VRAMBase, 'h8000, base OR'd onto the 13-bit destination offset

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
REG_WE  in  1  CPU register write strobe (one cycle)
REG_RE  in  1  CPU register read strobe
REG_ADDR  in  3  register select: 1..5 = FF51..FF55
REG_DIN  in  8  register write data
REG_DOUT  out  8  register read data, valid the cycle after REG_RE
HBLANK  in  1  PPU mode-0 level from video block
CPU_HALT  out  1  CPU must not issue bus cycles while high
CYC  out  1  Wishbone cycle
STB  out  1  Wishbone strobe
WE  out  1  Wishbone write enable
ADDR  out  AddressWidth  Wishbone address
DAT_ToTarget  out  DataWidth  write data
DAT_ToInitiator  in  DataWidth  read data
ACK  in  1  Wishbone acknowledge
STALL  in  1  Wishbone pipelined stall

Behaviour:
- Reset (async, active-high): state IDLE; CYC=STB=WE=0; ADDR=0; DAT_ToTarget=0; CPU_HALT=0; REG_DOUT=0; SRC=0xFFF0; DST=0x1FF0; REMAIN=0x7F; ACTIVE=0; HDMA5 reads 0xFF.
- Register writes:
  - FF51 sets SRC[15:8]; FF52 sets SRC[7:4]; SRC[3:0] is forced to 0.
  - FF53 sets DST[12:8] from REG_DIN[4:0]; FF54 sets DST[7:4]; DST[3:0] is forced to 0.
  - Writes to FF51–FF54 while ACTIVE are accepted but take effect only at the next start.
- FF55 write:
  - Not ACTIVE: REMAIN=REG_DIN[6:0]; MODE=REG_DIN[7] (0 = general, 1 = HBlank); ACTIVE=1. General mode enters RD_REQ on the next cycle.
  - ACTIVE in HBlank mode with bit7=0: cancel. ACTIVE=0 at the end of the current block, or immediately if between blocks. REMAIN is kept, so a read returns {1, REMAIN}.
  - ACTIVE in HBlank mode with bit7=1: restart with the new length. The current block completes first.
- FF55 read: ACTIVE gives {0, REMAIN}. Idle after completion gives 0xFF. Idle after cancel gives {1, REMAIN}. FF51–FF54 read 0xFF.
- States: IDLE, WAIT_HBL, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, BLK_END.
  - IDLE→RD_REQ on a general start.
  - IDLE→WAIT_HBL on an HBlank start.
  - WAIT_HBL→RD_REQ on the HBLANK rising edge. A start with HBLANK already high waits for the next rising edge.
  - RD_REQ: CYC=STB=1, WE=0, ADDR=SRC. Leaves when !STALL.
  - RD_WAIT: STB=0, CYC held. On ACK, latch DAT_ToInitiator.
  - WR_REQ: STB=1, WE=1, ADDR=VRAMBase|DST, DAT_ToTarget=latched byte. Leaves when !STALL.
  - WR_WAIT: on ACK, SRC+=1 and DST+=1. If DST[3:0] was 0xF go to BLK_END, else RD_REQ.
  - BLK_END: CYC=0. If REMAIN==0, ACTIVE=0, REMAIN=0x7F, go IDLE. Otherwise REMAIN-=1 and go to RD_REQ (general) or WAIT_HBL (HBlank).
- CYC stays high from RD_REQ through WR_WAIT. One outstanding request at a time; no pipelining across bytes.
- CPU_HALT is high whenever the state is not IDLE or WAIT_HBL. It rises in the cycle the state leaves IDLE/WAIT_HBL.
- Wrap rules:
  - SRC wraps 0xFFFF→0x0000; no range checks.
  - DST is 13 bits and wraps 0x1FFF→0x0000. The transfer continues after the wrap; it does not abort.
- A byte costs at least 4 cycles with zero-wait ACK, so one block takes ≥65 cycles including BLK_END.
- Reset asserted mid-transfer drops CYC/STB immediately and asynchronously; the partial block is lost.
- REG_WE to FF55 in the same cycle as BLK_END with REMAIN==0: the write wins and starts a new transfer.

Decomposition:
- Package gbc_hdma_pkg holds:
  - state enum hdma_state_t;
  - register index constants HDMA1..HDMA5;
  - VRAM_OFFSET_W=13;
  - BLOCK_BYTES=16.
- One natural sub-module, gbc_hdma_regs: register file, FF55 read mux, start/cancel decode.
- The FSM and Wishbone driver stay in gbc_hdma_engine.

Test Plan:
- Write FF51=0x20, FF52=0x00, FF53=0x00, FF54=0x00, FF55=0x01 with zero-wait ACK target → 32 reads 0x2000–0x201F, each followed by a write to 0x8000–0x801F with the read byte. CPU_HALT high throughout. FF55 then reads 0xFF.
- HBlank mode FF55=0x82, HBLANK pulsed 3 times → exactly 16 bytes per pulse. CPU_HALT low between pulses. FF55 reads 0x01, 0x00, then 0xFF after each block.
- HBlank mode FF55=0x85, then write FF55=0x00 after the second block → no further transfers on later HBLANK pulses. FF55 reads 0x83.
- DST set to 0x1FF0 (FF53=0x1F, FF54=0xF0), FF55=0x01 → writes 0x9FF0–0x9FFF, then 0x8000–0x800F.
- Target asserts STALL 3 cycles per request and ACK 2 cycles late → same data as the first scenario, STB held until !STALL, never two outstanding requests.
- RST pulsed mid-block → CYC=STB=CPU_HALT=0 in the same cycle. FF55 reads 0xFF. A new FF55=0x00 transfers exactly 16 bytes.

Source files
------------

// File: rtl/gbc_hdma_pkg.sv
// Shared types and constants for the GBC VRAM DMA (HDMA) engine.
package gbc_hdma_pkg;

  typedef enum logic [2:0] {
    IDLE, WAIT_HBL, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, BLK_END
  } hdma_state_t;

  localparam logic [2:0] HDMA1 = 3'd1;
  localparam logic [2:0] HDMA2 = 3'd2;
  localparam logic [2:0] HDMA3 = 3'd3;
  localparam logic [2:0] HDMA4 = 3'd4;
  localparam logic [2:0] HDMA5 = 3'd5;

  localparam int VRAM_OFFSET_W = 13;
  localparam int BLOCK_BYTES   = 16;

  localparam logic [15:0]              SRC_RST    = 16'hFFF0;
  localparam logic [VRAM_OFFSET_W-1:0] DST_RST    = 13'h1FF0;
  localparam logic [6:0]               REMAIN_RST = 7'h7F;

  // The CPU keeps the bus only while the engine is parked.
  function automatic logic is_busy(hdma_state_t s);
    return (s != IDLE) && (s != WAIT_HBL);
  endfunction

endpackage

// File: rtl/gbc_hdma_regs.sv
// FF51-FF55 register file: source/destination config, block counter,
// FF55 read mux and start/cancel/restart decode for the transfer FSM.
module gbc_hdma_regs
  import gbc_hdma_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [2:0]               i_addr,
  input  logic [7:0]               i_din,
  output logic [7:0]               o_dout,
  input  logic                     i_blk_end,
  input  logic                     i_between,
  output logic [15:0]              o_src_cfg,
  output logic [VRAM_OFFSET_W-1:0] o_dst_cfg,
  output logic                     o_start,
  output logic                     o_go_rd,
  output logic                     o_go_hbl,
  output logic                     o_cancel_now
);

  logic [11:0] r_src_hi;
  logic [8:0]  r_dst_hi;
  logic [6:0]  r_remain;
  logic [6:0]  r_restart_len;
  logic        r_mode;
  logic        r_active;
  logic        r_cancel_pend;
  logic        r_restart_pend;
  logic [7:0]  r_dout;

  logic w_wr55, w_last, w_free, w_hbl_wr, w_at_gap, w_cont;

  assign w_wr55   = i_we && (i_addr == HDMA5);
  // This block end finishes the transfer (count exhausted or cancel queued).
  assign w_last   = i_blk_end && !r_restart_pend && ((r_remain == 7'd0) || r_cancel_pend);
  assign w_free   = !r_active || w_last;
  assign o_start  = w_wr55 && w_free;
  assign w_hbl_wr = w_wr55 && !w_free && r_mode;
  // Block boundaries: a write here acts at once instead of being queued.
  assign w_at_gap = i_between || i_blk_end;
  assign o_cancel_now = w_hbl_wr && !i_din[7] && w_at_gap;
  assign w_cont   = i_blk_end && !w_last && !o_cancel_now;
  assign o_go_rd  = (o_start && !i_din[7]) || (w_cont && !r_mode);
  assign o_go_hbl = (o_start && i_din[7])  || (w_cont && r_mode);

  assign o_src_cfg = {r_src_hi, 4'h0};
  assign o_dst_cfg = {r_dst_hi, 4'h0};
  assign o_dout    = r_dout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src_hi       <= SRC_RST[15:4];
      r_dst_hi       <= DST_RST[VRAM_OFFSET_W-1:4];
      r_remain       <= REMAIN_RST;
      r_restart_len  <= 7'd0;
      r_mode         <= 1'b0;
      r_active       <= 1'b0;
      r_cancel_pend  <= 1'b0;
      r_restart_pend <= 1'b0;
      r_dout         <= 8'h00;
    end else begin
      if (i_we) begin
        case (i_addr)
          HDMA1:   r_src_hi[11:4] <= i_din;
          HDMA2:   r_src_hi[3:0]  <= i_din[7:4];
          HDMA3:   r_dst_hi[8:4]  <= i_din[4:0];
          HDMA4:   r_dst_hi[3:0]  <= i_din[7:4];
          default: ;
        endcase
      end
      if (i_re)
        r_dout <= (i_addr == HDMA5) ? {~r_active, r_remain} : 8'hFF;

      if (o_start) begin
        r_remain       <= i_din[6:0];
        r_mode         <= i_din[7];
        r_active       <= 1'b1;
        r_cancel_pend  <= 1'b0;
        r_restart_pend <= 1'b0;
      end else begin
        if (i_blk_end) begin
          if (r_restart_pend) begin
            r_remain       <= r_restart_len;
            r_restart_pend <= 1'b0;
          end else if (r_remain == 7'd0) begin
            r_active      <= 1'b0;
            r_remain      <= REMAIN_RST;
            r_cancel_pend <= 1'b0;
          end else begin
            r_remain <= r_remain - 7'd1;
            if (r_cancel_pend) begin
              r_active      <= 1'b0;
              r_cancel_pend <= 1'b0;
            end
          end
        end
        // Later assignments override the block-end bookkeeping above.
        if (w_hbl_wr) begin
          if (i_din[7]) begin
            r_cancel_pend <= 1'b0;
            if (w_at_gap) begin
              r_remain       <= i_din[6:0];
              r_restart_pend <= 1'b0;
            end else begin
              r_restart_pend <= 1'b1;
              r_restart_len  <= i_din[6:0];
            end
          end else begin
            r_restart_pend <= 1'b0;
            if (w_at_gap) r_active      <= 1'b0;
            else          r_cancel_pend <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/gbc_hdma_engine.sv
// GBC HDMA engine: copies 16-byte blocks into VRAM as a second Wishbone
// initiator, one outstanding byte access at a time, general or HBlank paced.
module gbc_hdma_engine
  import gbc_hdma_pkg::*;
#(
  parameter int                      AddressWidth = 16,
  parameter int                      DataWidth    = 8,
  parameter logic [AddressWidth-1:0] VRAMBase     = 'h8000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REG_WE,
  input  logic                    REG_RE,
  input  logic [2:0]              REG_ADDR,
  input  logic [7:0]              REG_DIN,
  output logic [7:0]              REG_DOUT,
  input  logic                    HBLANK,
  output logic                    CPU_HALT,
  output logic                    CYC,
  output logic                    STB,
  output logic                    WE,
  output logic [AddressWidth-1:0] ADDR,
  output logic [DataWidth-1:0]    DAT_ToTarget,
  input  logic [DataWidth-1:0]    DAT_ToInitiator,
  input  logic                    ACK,
  input  logic                    STALL
);

  localparam logic [3:0] BLK_LAST = 4'(BLOCK_BYTES - 1);

  hdma_state_t                r_state, w_next;
  logic [15:0]                r_src;
  logic [VRAM_OFFSET_W-1:0]   r_dst;
  logic [DataWidth-1:0]       r_data;
  logic                       r_hbl_d;

  logic [15:0]                w_src_cfg;
  logic [VRAM_OFFSET_W-1:0]   w_dst_cfg;
  logic w_start, w_go_rd, w_go_hbl, w_cancel_now, w_hbl_rise;

  assign w_hbl_rise = HBLANK && !r_hbl_d;

  gbc_hdma_regs u_regs (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_we         (REG_WE),
    .i_re         (REG_RE),
    .i_addr       (REG_ADDR),
    .i_din        (REG_DIN),
    .o_dout       (REG_DOUT),
    .i_blk_end    (r_state == BLK_END),
    .i_between    (r_state == WAIT_HBL),
    .o_src_cfg    (w_src_cfg),
    .o_dst_cfg    (w_dst_cfg),
    .o_start      (w_start),
    .o_go_rd      (w_go_rd),
    .o_go_hbl     (w_go_hbl),
    .o_cancel_now (w_cancel_now)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    CYC    = 1'b0;
    STB    = 1'b0;
    WE     = 1'b0;
    ADDR   = '0;
    case (r_state)
      IDLE: begin
        if (w_go_rd)       w_next = RD_REQ;
        else if (w_go_hbl) w_next = WAIT_HBL;
      end
      WAIT_HBL: begin
        if (w_cancel_now)    w_next = IDLE;
        else if (w_hbl_rise) w_next = RD_REQ;
      end
      RD_REQ: begin
        CYC  = 1'b1;
        STB  = 1'b1;
        ADDR = AddressWidth'(r_src);
        if (!STALL) w_next = RD_WAIT;
      end
      RD_WAIT: begin
        CYC  = 1'b1;
        ADDR = AddressWidth'(r_src);
        if (ACK) w_next = WR_REQ;
      end
      WR_REQ: begin
        CYC  = 1'b1;
        STB  = 1'b1;
        WE   = 1'b1;
        ADDR = VRAMBase | AddressWidth'(r_dst);
        if (!STALL) w_next = WR_WAIT;
      end
      WR_WAIT: begin
        CYC  = 1'b1;
        WE   = 1'b1;
        ADDR = VRAMBase | AddressWidth'(r_dst);
        if (ACK) w_next = (r_dst[3:0] == BLK_LAST) ? BLK_END : RD_REQ;
      end
      BLK_END: begin
        if (w_go_rd)       w_next = RD_REQ;
        else if (w_go_hbl) w_next = WAIT_HBL;
        else               w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Raised already in the cycle that leaves IDLE/WAIT_HBL.
  assign CPU_HALT     = is_busy(r_state) || is_busy(w_next);
  assign DAT_ToTarget = r_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_src   <= SRC_RST;
      r_dst   <= DST_RST;
      r_data  <= '0;
      r_hbl_d <= 1'b0;
    end else begin
      r_hbl_d <= HBLANK;
      if (w_start) begin
        r_src <= w_src_cfg;
        r_dst <= w_dst_cfg;
      end else if (r_state == WR_WAIT && ACK) begin
        r_src <= r_src + 16'd1;
        r_dst <= r_dst + 1'b1;
      end
      if (r_state == RD_WAIT && ACK) r_data <= DAT_ToInitiator;
    end
  end

endmodule

// File: tb/tb_gbc_hdma_engine.sv
// Scoreboard bench for gbc_hdma_engine: stimulus queues expected bus beats
// and register reads, a negedge monitor pops and compares them.
module tb_gbc_hdma_engine;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_t;

  logic        CLK, RST, REG_WE, REG_RE, HBLANK;
  logic [2:0]  REG_ADDR;
  logic [7:0]  REG_DIN, REG_DOUT;
  logic        CPU_HALT, CYC, STB, WE, ACK, STALL;
  logic [15:0] ADDR;
  logic [7:0]  DAT_ToTarget, DAT_ToInitiator;

  gbc_hdma_engine dut (
    .CLK(CLK), .RST(RST), .REG_WE(REG_WE), .REG_RE(REG_RE),
    .REG_ADDR(REG_ADDR), .REG_DIN(REG_DIN), .REG_DOUT(REG_DOUT),
    .HBLANK(HBLANK), .CPU_HALT(CPU_HALT), .CYC(CYC), .STB(STB), .WE(WE),
    .ADDR(ADDR), .DAT_ToTarget(DAT_ToTarget), .DAT_ToInitiator(DAT_ToInitiator),
    .ACK(ACK), .STALL(STALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  bus_t bq[$];
  logic [7:0] rq[$];

  int stall_cfg = 0;
  int ack_lat   = 0;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Wishbone target: programmable stall per request and ack latency.
  logic [15:0] acc_addr;
  logic        acc_we, ack_pend;
  int          ack_wait, stall_left;
  initial begin
    ACK = 0; STALL = 0; DAT_ToInitiator = 0; ack_pend = 0; ack_wait = 0; stall_left = 0;
    acc_addr = 0; acc_we = 0;
    forever begin
      @(posedge CLK); #1;
      if (RST) begin
        ACK = 0; STALL = 0; ack_pend = 0; stall_left = stall_cfg;
      end else begin
        ACK = 0;
        if (ack_pend) begin
          if (ack_wait == 0) begin
            ACK = 1;
            DAT_ToInitiator = acc_we ? 8'h00 : pat(acc_addr);
            ack_pend = 0;
          end else ack_wait--;
        end
        if (CYC && STB) begin
          if (stall_left > 0) begin
            STALL = 1; stall_left--;
          end else begin
            STALL = 0; ack_pend = 1; ack_wait = ack_lat; acc_addr = ADDR; acc_we = WE;
          end
        end else begin
          STALL = 0; stall_left = stall_cfg;
        end
      end
    end
  end

  // Monitor
  logic        re_q = 1'b0;
  int          outst = 0;
  logic        stb_wait = 1'b0;
  logic [15:0] held_addr = '0;
  always @(posedge CLK) re_q <= REG_RE;

  always @(negedge CLK) begin
    if (RST) begin
      outst = 0; stb_wait = 0;
    end else begin
      if (ACK && CYC) outst--;
      if (stb_wait) begin
        chk("stb_held", STB, 1'b1);
        chk("stb_addr_held", ADDR, held_addr);
      end
      stb_wait  = CYC && STB && STALL;
      held_addr = ADDR;
      if (CYC && STB && !STALL) begin
        bus_t e;
        n_acc++;
        chk("outstanding", outst, 0);
        outst++;
        chk("halt_during_bus", CPU_HALT, 1'b1);
        if (bq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL bus_unexpected: got we=%0b addr=%h expected no access", WE, ADDR);
        end else begin
          e = bq.pop_front();
          chk("bus_we", WE, e.we);
          chk("bus_addr", ADDR, e.addr);
          if (e.we) chk("bus_wdata", DAT_ToTarget, e.data);
        end
      end
      if (re_q) begin
        if (rq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL reg_unexpected: got %h expected no read", REG_DOUT);
        end else chk("reg_read", REG_DOUT, rq.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge CLK); #1; REG_WE = 1; REG_ADDR = a; REG_DIN = d;
    @(posedge CLK); #1; REG_WE = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp);
    rq.push_back(exp);
    @(posedge CLK); #1; REG_RE = 1; REG_ADDR = a;
    @(posedge CLK); #1; REG_RE = 0;
  endtask

  task automatic push_xfer(input logic [15:0] src, input logic [12:0] dst, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] s;
      logic [12:0] d;
      s = src + 16'(i);
      d = dst + 13'(i);
      bq.push_back('{we: 1'b0, addr: s, data: 8'h00});
      bq.push_back('{we: 1'b1, addr: 16'h8000 | {3'b000, d}, data: pat(s)});
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((bq.size() != 0 || CPU_HALT || CYC) && n < budget) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= budget) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got timeout after %0d cycles expected idle engine", name, budget);
    end
  endtask

  task automatic pulse_hbl();
    @(posedge CLK); #1; HBLANK = 1;
    cycles(4);
    HBLANK = 0;
  endtask

  task automatic set_regs(input logic [7:0] h1, h2, h3, h4);
    wr(3'd1, h1); wr(3'd2, h2); wr(3'd3, h3); wr(3'd4, h4);
  endtask

  initial begin
    int acc0;
    RST = 0; REG_WE = 0; REG_RE = 0; REG_ADDR = 0; REG_DIN = 0; HBLANK = 0;
    #2 RST = 1;
    cycles(3);
    RST = 0;

    // reset state
    chk("rst_cyc", CYC, 1'b0);
    chk("rst_stb", STB, 1'b0);
    chk("rst_we", WE, 1'b0);
    chk("rst_addr", ADDR, 16'h0000);
    chk("rst_wdata", DAT_ToTarget, 8'h00);
    chk("rst_halt", CPU_HALT, 1'b0);
    chk("rst_dout", REG_DOUT, 8'h00);
    rd(3'd5, 8'hFF);

    // general mode, 2 blocks from 0x2000 to 0x8000
    set_regs(8'h20, 8'h00, 8'h00, 8'h00);
    push_xfer(16'h2000, 13'h0000, 32);
    wr(3'd5, 8'h01);
    drain("gen_drain", 2000);
    rd(3'd5, 8'hFF);
    rd(3'd1, 8'hFF);

    // HBlank mode, 3 blocks, one per pulse
    set_regs(8'h40, 8'h10, 8'h05, 8'h20);
    acc0 = n_acc;
    wr(3'd5, 8'h82);
    cycles(8);
    chk("hbl_no_early_xfer", n_acc, acc0);
    chk("hbl_halt_waiting", CPU_HALT, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push_xfer(16'h4010 + 16'(16 * k), 13'h0520 + 13'(16 * k), 16);
      pulse_hbl();
      drain("hbl_drain", 1000);
      chk("hbl_halt_between", CPU_HALT, 1'b0);
      rd(3'd5, (k == 0) ? 8'h01 : (k == 1) ? 8'h00 : 8'hFF);
    end
    acc0 = n_acc;
    pulse_hbl();
    cycles(80);
    chk("hbl_done_no_xfer", n_acc, acc0);

    // HBlank start with HBLANK already high, cancel after second block
    HBLANK = 1;
    cycles(2);
    acc0 = n_acc;
    wr(3'd5, 8'h85);
    cycles(10);
    chk("hbl_high_start_waits", n_acc, acc0);
    HBLANK = 0;
    for (int k = 0; k < 2; k++) begin
      push_xfer(16'h4010 + 16'(16 * k), 13'h0520 + 13'(16 * k), 16);
      pulse_hbl();
      drain("cancel_drain", 1000);
    end
    rd(3'd5, 8'h03);
    wr(3'd5, 8'h00);
    rd(3'd5, 8'h83);
    acc0 = n_acc;
    pulse_hbl(); cycles(80);
    pulse_hbl(); cycles(80);
    chk("cancel_no_xfer", n_acc, acc0);
    rd(3'd5, 8'h83);

    // destination wraps 0x1FFF -> 0x0000
    set_regs(8'h12, 8'h30, 8'h1F, 8'hF0);
    push_xfer(16'h1230, 13'h1FF0, 32);
    wr(3'd5, 8'h01);
    drain("wrap_drain", 2000);

    // stalling, late-acking target
    stall_cfg = 3; ack_lat = 2;
    set_regs(8'h20, 8'h00, 8'h00, 8'h00);
    push_xfer(16'h2000, 13'h0000, 32);
    wr(3'd5, 8'h01);
    drain("stall_drain", 4000);
    stall_cfg = 0; ack_lat = 0;
    rd(3'd5, 8'hFF);

    // async reset mid-block
    push_xfer(16'h2000, 13'h0000, 16);
    wr(3'd5, 8'h00);
    cycles(20);
    chk("pre_rst_cyc", CYC, 1'b1);
    @(posedge CLK); #3; RST = 1;
    #1;
    chk("async_rst_cyc", CYC, 1'b0);
    chk("async_rst_stb", STB, 1'b0);
    chk("async_rst_halt", CPU_HALT, 1'b0);
    @(posedge CLK); #1; RST = 0;
    bq.delete();
    rd(3'd5, 8'hFF);
    acc0 = n_acc;
    push_xfer(16'hFFF0, 13'h1FF0, 16);
    wr(3'd5, 8'h00);
    drain("post_rst_drain", 1000);
    chk("post_rst_count", n_acc - acc0, 32);
    rd(3'd5, 8'hFF);

    cycles(2);
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
